// File: rtl/cla_seq_mul_if.sv
// Request/response bundle for the shift-add multiplier: operand pair in,
// ready/busy/done status and the held product out.
interface cla_seq_mul_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/cla_seq_mul.sv
// Unsigned sequential multiplier: one add-and-shift per clock through a single
// WIDTH-bit carry-look-ahead adder, 2*WIDTH-bit product after WIDTH iterations.
module cla_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    cla_seq_mul_if.slave      bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_product;

    logic [WIDTH-1:0]       w_p;
    logic [WIDTH-1:0]       w_g;
    logic [WIDTH:0]         w_carry;
    logic [WIDTH-1:0]       w_sum;
    logic                   w_cout;
    logic [2*WIDTH-1:0]     w_acc_nxt;
    logic                   w_ready;
    logic                   w_busy;
    logic                   w_done;

    assign w_p = r_hi ^ r_mcand;
    assign w_g = r_hi & r_mcand;

    // Every carry is a flat sum-of-products over p/g, so no carry depends on
    // the previous bit's resolved carry.
    always_comb begin
        logic v_term;
        w_carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j <= i; j++) begin
                v_term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    v_term = v_term & w_p[k];
                end
                w_carry[i+1] = w_carry[i+1] | v_term;
            end
        end
    end

    assign w_sum  = w_p ^ w_carry[WIDTH-1:0];
    assign w_cout = w_carry[WIDTH];

    assign w_acc_nxt = r_lo[0] ? {w_cout, w_sum, r_lo[WIDTH-1:1]}
                               : {1'b0,   r_hi,  r_lo[WIDTH-1:1]};

    // NOTE: state registers use non-blocking assignments so all flops update
    // from pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_CNT) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mcand <= bus.a;
                        r_hi    <= '0;
                        r_lo    <= bus.b;
                        r_cnt   <= '0;
                    end
                end
                S_BUSY: begin
                    {r_hi, r_lo} <= w_acc_nxt;
                    r_cnt        <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) r_product <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready   = w_ready;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.product = r_product;
endmodule

// File: tb/tb_cla_seq_mul.sv
// Directed and random checks of cla_seq_mul against a plain a*b reference,
// including handshake timing, ignored starts, mid-operation reset and back-to-back.
module tb_cla_seq_mul;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;
    logic [63:0] last_product;

    cla_seq_mul_if #(.WIDTH(W)) bus ();

    cla_seq_mul #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    // One full operation from IDLE: accept, count busy cycles, check the result.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_op);
        int n_busy;
        bit onehot_ok;
        bit held_ok;
        logic [63:0] exp;
        exp = ref_mul(ta, tb_op);
        check({tag, "_ready_pre"}, 64'(bus.ready), 64'd1);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_op;
        tick();
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        n_busy    = 0;
        onehot_ok = 1'b1;
        held_ok   = 1'b1;
        while (bus.busy === 1'b1 && n_busy < 100) begin
            if ($countones({bus.ready, bus.busy, bus.done}) != 1) onehot_ok = 1'b0;
            if (bus.product !== last_product) held_ok = 1'b0;
            n_busy++;
            tick();
        end
        check({tag, "_busy_len"}, 64'(n_busy), 64'd32);
        check({tag, "_onehot"}, 64'(onehot_ok), 64'd1);
        check({tag, "_held"}, 64'(held_ok), 64'd1);
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_product"}, bus.product, exp);
        tick();
        check({tag, "_ready_post"}, 64'({bus.ready, bus.busy, bus.done}), 64'b100);
        last_product = exp;
    endtask

    initial begin
        int n;
        int acc_cyc;
        int acc2_cyc;
        bit flag;
        n_checks     = 0;
        n_errors     = 0;
        cyc          = 0;
        last_product = '0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        tick();
        tick();
        check("reset_status", 64'({bus.ready, bus.busy, bus.done}), 64'b100);
        check("reset_product", bus.product, 64'd0);
        rst = 1'b0;
        tick();

        do_op("basic", 32'd3, 32'd5);
        do_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("b_zero", 32'h1234_5678, 32'd0);
        do_op("b_one", 32'h1234_5678, 32'd1);

        // Start pulses during BUSY must not disturb the in-flight 7*9.
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd9;
        tick();
        acc_cyc   = cyc;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (n == 5) begin
                bus.start = 1'b1;
                bus.a     = 32'd2;
                bus.b     = 32'd2;
            end
            if (n == 15) bus.start = 1'b0;
            n++;
            tick();
        end
        bus.start = 1'b0;
        check("ign_busy_len", 64'(n), 64'd32);
        check("ign_done_cycle", 64'(cyc - acc_cyc), 64'd32);
        check("ign_done", 64'(bus.done), 64'd1);
        check("ign_product", bus.product, 64'd63);
        tick();
        check("ign_ready", 64'(bus.ready), 64'd1);
        tick();
        check("ign_no_second", 64'({bus.ready, bus.busy, bus.done}), 64'b100);
        last_product = 64'd63;

        // Reset ten cycles into BUSY aborts without a done pulse.
        bus.start = 1'b1;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h10;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        check("rst_mid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_status", 64'({bus.ready, bus.busy, bus.done}), 64'b100);
        check("rst_product", bus.product, 64'd0);
        flag = 1'b0;
        repeat (40) begin
            tick();
            if (bus.done !== 1'b0 || bus.ready !== 1'b1) flag = 1'b1;
        end
        check("rst_no_done", 64'(flag), 64'd0);
        last_product = 64'd0;
        do_op("after_rst", 32'd6, 32'd7);

        // Back-to-back with start held high.
        bus.start = 1'b1;
        bus.a     = 32'h1_0000;
        bus.b     = 32'h1_0000;
        tick();
        acc_cyc = cyc;
        bus.a   = 32'hFFFF;
        bus.b   = 32'h2;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("b2b_first", bus.product, 64'h0000_0001_0000_0000);
        tick();
        check("b2b_ready", 64'(bus.ready), 64'd1);
        tick();
        acc2_cyc = cyc;
        check("b2b_spacing", 64'(acc2_cyc - acc_cyc), 64'd34);
        check("b2b_busy2", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        flag = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.product !== 64'h0000_0001_0000_0000) flag = 1'b1;
            n++;
            tick();
        end
        check("b2b_stable", 64'(flag), 64'd0);
        check("b2b_second", bus.product, 64'h0000_0000_0001_FFFE);
        tick();
        last_product = 64'h0000_0000_0001_FFFE;

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            do_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cla_seq_mul.md
# cla_seq_mul

Sequential shift-add multiplier controller that time-shares one WIDTH-bit carry-look-ahead adder slice (propagate/generate stage plus carry resolution) to form an unsigned 2·WIDTH-bit product. It sits beside the ALU's adder datapath and serves the multiply opcode. It takes one operand pair per request over a start/ready/done handshake and performs one add-and-shift iteration per clock.

## Interface

- WIDTH, 32, operand width in bits; product is 2·WIDTH bits; legal range 4..32.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on a cycle where ready=1.
- a  input  WIDTH  multiplicand, unsigned; sampled on accept.
- b  input  WIDTH  multiplier, unsigned; sampled on accept.
- ready  output  1  high in IDLE only.
- busy  output  1  high in BUSY only.
- done  output  1  one-cycle pulse, high in DONE only.
- product  output  2·WIDTH  a·b of the last completed operation; held until the next completion.

## Operation

- Internal registers:
  - mcand (WIDTH), the multiplicand.
  - hi (WIDTH) and lo (WIDTH), forming the accumulator/multiplier shift pair.
  - cnt (ceil(log2 WIDTH) bits).
  - state.
  - product register.
- Adder: p = hi ^ mcand, g = hi & mcand. Carries are resolved look-ahead style from p/g with carry-in 0. The adder yields sum (WIDTH) and cout (1).
- IDLE:
  - start=1 loads mcand←a, hi←0, lo←b, cnt←0, then goes to BUSY.
  - start=0 stays in IDLE.
- BUSY, every cycle:
  - If lo[0]=1, {hi,lo} ← {cout, sum, lo[WIDTH-1:1]}.
  - Otherwise {hi,lo} ← {1'b0, hi, lo[WIDTH-1:1]}.
  - cnt ← cnt+1.
  - When cnt = WIDTH-1, the final iteration executes, product ← the post-iteration {hi,lo}, and the state goes to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- start in BUSY or DONE is ignored: no queuing, no operand capture, no effect on the in-flight result.
- Operands a/b may change freely after the accept cycle.
- Arithmetic:
  - Unsigned only. Each iteration is modulo-free because cout is kept as the shifted-in MSB.
  - The final product is exact; there is no overflow.
- Reset:
  - The cycle after rst is sampled high: IDLE, ready=1, busy=0, done=0, product=0, internal registers 0.
  - rst mid-BUSY or in DONE aborts the operation. No done pulse is produced and product is cleared to 0.
  - rst takes priority over a simultaneous start.

## Timing

- Accept at edge k (IDLE, start=1).
- busy=1 for cycles k+1 … k+WIDTH, exactly WIDTH cycles.
- done=1 and product valid in cycle k+WIDTH+1.
- ready=1 again in cycle k+WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles with start held high.
- Latency is data-independent: b=0 or b=1 take the full WIDTH iterations.
- ready, busy and done are decoded directly from the state register. They are mutually exclusive and exactly one is high outside reset.
- product changes only on the BUSY→DONE edge or on reset.

## Test plan

- **Basic multiply.** Reset, then a=3, b=5, start for 1 cycle.
  - busy high 32 cycles.
  - done one cycle later with product=0x000000000000000F.
  - ready returns the next cycle.
- **Maximum operands.** a=0xFFFFFFFF, b=0xFFFFFFFF → product=0xFFFFFFFE00000001. This exercises cout capture every iteration.
- **Degenerate multipliers.**
  - a=0x12345678, b=0 → product 0.
  - Then b=1 → 0x0000000012345678.
  - Both still take 32 BUSY cycles.
- **Start ignored while busy.** Accept a=7, b=9. At BUSY cycle 5, drive start=1 with a=2, b=2 for 10 cycles. Required: done once at k+33 with product=63, and no second operation starts.
- **Reset mid-operation.** Accept a=0xDEADBEEF, b=0x10, assert rst at BUSY cycle 10.
  - Next cycle: ready=1, busy=0, product=0, and no done pulse.
  - A following a=6, b=7 yields 42.
- **Back-to-back with start held high.** Operands 0x10000,0x10000 then 0xFFFF,0x2.
  - Accepts are 34 cycles apart.
  - Products are 0x0000000100000000 then 0x000000000001FFFE.
  - product stays stable between the two done pulses.
